// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - core configuration types and defaults shared by the register file
package config_pkg;

  localparam int unsigned XLEN        = 32;
  localparam bit          E_SUPPORTED = 1'b0;

  typedef logic [4:0] regaddr_t;

  typedef struct packed {
    logic [31:0] xlen;
    logic        e_supported;
  } config_t;

  localparam config_t DEFAULT_CONF = '{xlen: XLEN, e_supported: E_SUPPORTED};

endpackage

// File: rtl/core_scoreboard.sv
// rtl/core_scoreboard.sv - busy-bit scoreboard with issue/clear/flush and read stall query
module core_scoreboard
  import config_pkg::*;
#(
  parameter int NRP    = 2,
  parameter int NWP    = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  regaddr_t             iss_rd,
  input  logic                 iss_v,
  input  regaddr_t [NWP-1:0]   wa,
  input  logic     [NWP-1:0]   wv,
  input  logic                 flush,
  input  regaddr_t [NRP-1:0]   ra,
  output logic     [NRP-1:0]   rstall
);

  logic [31:0]    busy_q, busy_d;
  logic [NRP-1:0] hit;

  // Next busy vector: writes retire producers, a new issue wins over a same-cycle retire,
  // flush kills everything including the issue of this cycle.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NWP; i++) begin
      if (wv[i]) busy_d[wa[i]] = 1'b0;
    end
    if (iss_v) busy_d[iss_rd] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  // Busy register, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Stall query: a busy operand is satisfied when its producer writes back this cycle and forwarding is on.
  always_comb begin
    hit    = '0;
    rstall = '0;
    for (int p = 0; p < NRP; p++) begin
      for (int i = 0; i < NWP; i++) begin
        if (BYPASS && wv[i] && (wa[i] == ra[p])) hit[p] = 1'b1;
      end
      rstall[p] = rst_n && busy_q[ra[p]] && !hit[p];
    end
  end

endmodule

// File: rtl/core_regfile_sb.sv
// rtl/core_regfile_sb.sv - multi-port register file with write priority, bypass and scoreboard
module core_regfile_sb
  import config_pkg::*;
#(
  parameter config_t CONF   = DEFAULT_CONF,
  parameter int      NRP    = 2,
  parameter int      NWP    = 2,
  parameter bit      BYPASS = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  regaddr_t [NRP-1:0]               ra,
  output logic     [NRP-1:0][CONF.xlen-1:0] rd,
  output logic     [NRP-1:0]               rstall,
  input  regaddr_t [NWP-1:0]               wa,
  input  logic     [NWP-1:0][CONF.xlen-1:0] wd,
  input  logic     [NWP-1:0]               we,
  input  regaddr_t                         iss_rd,
  input  logic                             iss_v,
  input  logic                             flush,
  output logic                             err
);

  localparam bit E_MODE  = CONF.e_supported;
  localparam int NUMREGS = E_MODE ? 16 : 32;
  localparam int IW      = E_MODE ? 4 : 5;

  logic [CONF.xlen-1:0] regs_q [NUMREGS];
  logic [CONF.xlen-1:0] regs_d [NUMREGS];
  logic [NWP-1:0]       wv;
  logic                 iss_ok;
  logic                 bad;
  logic                 err_q, err_d;

  function automatic logic in_range(input regaddr_t a);
    return !E_MODE || !a[4];
  endfunction

  // Qualified write/issue enables: x0 and out-of-range targets are dropped here once for everyone.
  always_comb begin
    wv = '0;
    for (int i = 0; i < NWP; i++) begin
      wv[i] = we[i] && (wa[i] != '0) && in_range(wa[i]);
    end
    iss_ok = iss_v && (iss_rd != '0) && in_range(iss_rd);
  end

  // Sticky error: any out-of-range address presented on a read, an enabled write or a valid issue.
  always_comb begin
    bad = 1'b0;
    if (E_MODE) begin
      for (int p = 0; p < NRP; p++) bad = bad | ra[p][4];
      for (int i = 0; i < NWP; i++) bad = bad | (we[i] & wa[i][4]);
      bad = bad | (iss_v & iss_rd[4]);
    end
    err_d = err_q | bad;
  end

  // Write merge: ports applied in ascending order so the highest index lands last.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NWP; i++) begin
      if (wv[i]) regs_d[wa[i][IW-1:0]] = wd[i];
    end
  end

  // Storage and error flag, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUMREGS; r++) regs_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      err_q  <= err_d;
    end
  end

  // Read muxes: stored value, overridden by same-cycle writes with the highest port last; forced to 0 in reset.
  always_comb begin
    for (int p = 0; p < NRP; p++) begin
      rd[p] = '0;
      if (rst_n && (ra[p] != '0) && in_range(ra[p])) begin
        rd[p] = regs_q[ra[p][IW-1:0]];
        if (BYPASS) begin
          for (int i = 0; i < NWP; i++) begin
            if (wv[i] && (wa[i] == ra[p])) rd[p] = wd[i];
          end
        end
      end
    end
  end

  assign err = err_q;

  core_scoreboard #(
    .NRP    (NRP),
    .NWP    (NWP),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk    (clk),
    .rst_n  (rst_n),
    .iss_rd (iss_rd),
    .iss_v  (iss_ok),
    .wa     (wa),
    .wv     (wv),
    .flush  (flush),
    .ra     (ra),
    .rstall (rstall)
  );

endmodule

// File: tb/tb_core_regfile_sb.sv
// tb/tb_core_regfile_sb.sv - scoreboard-checked bench for core_regfile_sb (bypass, no-bypass, E-mode instances)
`timescale 1ns/1ps
module tb_core_regfile_sb;
  import config_pkg::*;

  localparam config_t CONF_E = '{xlen: 32'd32, e_supported: 1'b1};

  logic clk = 1'b0;
  logic rst_n;
  regaddr_t [1:0] ra, wa;
  logic [1:0][31:0] wd;
  logic [1:0] we;
  regaddr_t iss_rd;
  logic iss_v, flush;

  logic [1:0][31:0] rd_a, rd_b, rd_c;
  logic [1:0] st_a, st_b, st_c;
  logic err_a, err_b, err_c;

  typedef struct {
    string       name;
    int          inst;
    int          port;
    logic [31:0] rd;
    logic        stall;
    logic        err;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  core_regfile_sb dut_a (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_a), .rstall(st_a), .wa(wa), .wd(wd), .we(we),
    .iss_rd(iss_rd), .iss_v(iss_v), .flush(flush), .err(err_a));

  core_regfile_sb #(.BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_b), .rstall(st_b), .wa(wa), .wd(wd), .we(we),
    .iss_rd(iss_rd), .iss_v(iss_v), .flush(flush), .err(err_b));

  core_regfile_sb #(.CONF(CONF_E)) dut_c (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_c), .rstall(st_c), .wa(wa), .wd(wd), .we(we),
    .iss_rd(iss_rd), .iss_v(iss_v), .flush(flush), .err(err_c));

  exp_t        m_e;
  logic [31:0] m_rd;
  logic        m_st, m_err;

  // Monitor: every negative edge, drain the expectations queued for this cycle and compare.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      m_e = q.pop_front();
      case (m_e.inst)
        0:       begin m_rd = rd_a[m_e.port]; m_st = st_a[m_e.port]; m_err = err_a; end
        1:       begin m_rd = rd_b[m_e.port]; m_st = st_b[m_e.port]; m_err = err_b; end
        default: begin m_rd = rd_c[m_e.port]; m_st = st_c[m_e.port]; m_err = err_c; end
      endcase
      n_chk++;
      if (m_rd !== m_e.rd || m_st !== m_e.stall || m_err !== m_e.err) begin
        n_fail++;
        $display("FAIL %s: inst %0d port %0d got rd=%h rstall=%b err=%b, expected rd=%h rstall=%b err=%b",
                 m_e.name, m_e.inst, m_e.port, m_rd, m_st, m_err, m_e.rd, m_e.stall, m_e.err);
      end
    end
  end

  task automatic expect_rd(input string name, input int inst, input int port,
                           input logic [31:0] rdv, input logic stall, input logic errv);
    exp_t e;
    e.name = name; e.inst = inst; e.port = port; e.rd = rdv; e.stall = stall; e.err = errv;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; iss_v = 1'b0; iss_rd = '0; flush = 1'b0; wa = '0; wd = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ra = '0; idle();
    cyc();
    ra[0] = 5'd5;
    expect_rd("reset_a", 0, 0, 32'h0, 1'b0, 1'b0);
    expect_rd("reset_c", 2, 0, 32'h0, 1'b0, 1'b0);
    cyc();
    rst_n = 1'b1;

    // Same-cycle write/read of x5
    idle(); we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF; ra[0] = 5'd5;
    expect_rd("bypass_x5", 0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
    expect_rd("nobypass_x5", 1, 0, 32'h0, 1'b0, 1'b0);
    cyc();
    idle(); ra[0] = 5'd5;
    expect_rd("stored_x5_a", 0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
    expect_rd("stored_x5_b", 1, 0, 32'hDEADBEEF, 1'b0, 1'b0);
    cyc();

    // Two ports write x7, highest port wins
    idle(); we = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7; wd[0] = 32'h11; wd[1] = 32'h22; ra[1] = 5'd7;
    expect_rd("prio_bypass_a", 0, 1, 32'h22, 1'b0, 1'b0);
    expect_rd("prio_nobypass_b", 1, 1, 32'h0, 1'b0, 1'b0);
    expect_rd("no_err_c", 2, 0, 32'hDEADBEEF, 1'b0, 1'b0);
    cyc();
    idle(); ra[1] = 5'd7;
    expect_rd("prio_stored_a", 0, 1, 32'h22, 1'b0, 1'b0);
    expect_rd("prio_stored_b", 1, 1, 32'h22, 1'b0, 1'b0);
    cyc();

    // Issue x3, stall, then write-back clears
    idle(); iss_v = 1'b1; iss_rd = 5'd3; ra[0] = 5'd3;
    expect_rd("iss_x3_same", 0, 0, 32'h0, 1'b0, 1'b0);
    cyc();
    idle(); ra[0] = 5'd3;
    expect_rd("busy_x3_a", 0, 0, 32'h0, 1'b1, 1'b0);
    expect_rd("busy_x3_b", 1, 0, 32'h0, 1'b1, 1'b0);
    cyc();
    idle(); we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h55; ra[0] = 5'd3;
    expect_rd("wb_x3_a", 0, 0, 32'h55, 1'b0, 1'b0);
    expect_rd("wb_x3_b", 1, 0, 32'h0, 1'b1, 1'b0);
    cyc();
    idle(); ra[0] = 5'd3;
    expect_rd("after_wb_x3_a", 0, 0, 32'h55, 1'b0, 1'b0);
    expect_rd("after_wb_x3_b", 1, 0, 32'h55, 1'b0, 1'b0);
    cyc();

    // Issue and write x4 together, then flush with a discarded issue
    idle(); iss_v = 1'b1; iss_rd = 5'd4; we[0] = 1'b1; wa[0] = 5'd4; wd[0] = 32'h44; ra[0] = 5'd4;
    expect_rd("iss_wb_x4_a", 0, 0, 32'h44, 1'b0, 1'b0);
    expect_rd("iss_wb_x4_b", 1, 0, 32'h0, 1'b0, 1'b0);
    cyc();
    idle(); ra[0] = 5'd4;
    expect_rd("x4_busy_a", 0, 0, 32'h44, 1'b1, 1'b0);
    expect_rd("x4_busy_b", 1, 0, 32'h44, 1'b1, 1'b0);
    cyc();
    idle(); flush = 1'b1; iss_v = 1'b1; iss_rd = 5'd9; we[1] = 1'b1; wa[1] = 5'd10; wd[1] = 32'hAA;
    ra[0] = 5'd4; ra[1] = 5'd9;
    expect_rd("flush_cycle_x4", 0, 0, 32'h44, 1'b1, 1'b0);
    expect_rd("flush_cycle_x9", 0, 1, 32'h0, 1'b0, 1'b0);
    cyc();
    idle(); ra[0] = 5'd4; ra[1] = 5'd9;
    expect_rd("flushed_x4", 0, 0, 32'h44, 1'b0, 1'b0);
    expect_rd("flushed_iss_x9_a", 0, 1, 32'h0, 1'b0, 1'b0);
    expect_rd("flushed_iss_x9_b", 1, 1, 32'h0, 1'b0, 1'b0);
    cyc();
    idle(); ra[1] = 5'd10;
    expect_rd("flush_write_x10_a", 0, 1, 32'hAA, 1'b0, 1'b0);
    expect_rd("flush_write_x10_b", 1, 1, 32'hAA, 1'b0, 1'b0);
    cyc();

    // x0 writes and issues ignored
    idle(); we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hFFFFFFFF; iss_v = 1'b1; iss_rd = 5'd0; ra[0] = 5'd0;
    expect_rd("x0_same_a", 0, 0, 32'h0, 1'b0, 1'b0);
    expect_rd("x0_same_b", 1, 0, 32'h0, 1'b0, 1'b0);
    cyc();
    idle(); ra[0] = 5'd0;
    expect_rd("x0_after_a", 0, 0, 32'h0, 1'b0, 1'b0);
    cyc();

    // E mode: x20 out of range
    idle(); we[0] = 1'b1; wa[0] = 5'd20; wd[0] = 32'h1; ra[0] = 5'd20; ra[1] = 5'd5;
    expect_rd("e_x20_same_c", 2, 0, 32'h0, 1'b0, 1'b0);
    expect_rd("e_x5_c", 2, 1, 32'hDEADBEEF, 1'b0, 1'b0);
    expect_rd("x20_bypass_a", 0, 0, 32'h1, 1'b0, 1'b0);
    cyc();
    idle(); ra[0] = 5'd20;
    expect_rd("e_err_set_c", 2, 0, 32'h0, 1'b0, 1'b1);
    expect_rd("x20_stored_a", 0, 0, 32'h1, 1'b0, 1'b0);
    expect_rd("x20_stored_b", 1, 0, 32'h1, 1'b0, 1'b0);
    cyc();
    idle(); ra[0] = 5'd0; ra[1] = 5'd3;
    expect_rd("e_err_sticky_c", 2, 0, 32'h0, 1'b0, 1'b1);
    expect_rd("e_x3_c", 2, 1, 32'h55, 1'b0, 1'b1);
    cyc();

    // Reset in the middle of a write burst
    idle(); we[0] = 1'b1; wa[0] = 5'd6; wd[0] = 32'h66; iss_v = 1'b1; iss_rd = 5'd13;
    ra[0] = 5'd6; ra[1] = 5'd13;
    expect_rd("burst_x6_a", 0, 0, 32'h66, 1'b0, 1'b0);
    expect_rd("burst_x13_c", 2, 1, 32'h0, 1'b0, 1'b1);
    cyc();
    idle(); we[0] = 1'b1; wa[0] = 5'd12; wd[0] = 32'hCC; ra[0] = 5'd12; ra[1] = 5'd13;
    #1 rst_n = 1'b0;
    expect_rd("rst_rd_a", 0, 0, 32'h0, 1'b0, 1'b0);
    expect_rd("rst_stall_a", 0, 1, 32'h0, 1'b0, 1'b0);
    expect_rd("rst_err_c", 2, 0, 32'h0, 1'b0, 1'b0);
    cyc();
    rst_n = 1'b1;
    idle(); ra[0] = 5'd12; ra[1] = 5'd6;
    expect_rd("post_rst_x12_a", 0, 0, 32'h0, 1'b0, 1'b0);
    expect_rd("post_rst_x6_a", 0, 1, 32'h0, 1'b0, 1'b0);
    cyc();
    idle(); ra[0] = 5'd13;
    expect_rd("post_rst_x13_idle", 0, 0, 32'h0, 1'b0, 1'b0);
    we[0] = 1'b1; wa[0] = 5'd12; wd[0] = 32'h12; ra[1] = 5'd12;
    expect_rd("post_rst_wr_a", 0, 1, 32'h12, 1'b0, 1'b0);
    cyc();
    idle(); ra[1] = 5'd12;
    expect_rd("post_rst_stored_b", 1, 1, 32'h12, 1'b0, 1'b0);
    cyc();

    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/core_regfile_sb.md
CORE_REGFILE_SB -- requirements
Module: core_regfile_sb

Interface
REQ-001 Parameter CONF, default config_pkg default, supplies XLEN and E_SUPPORTED (NUMREGS = 16 if E_SUPPORTED else 32).
REQ-002 Parameter NRP, default 2, number of read ports (1..4).
REQ-003 Parameter NWP, default 2, number of write ports (1..3).
REQ-004 Parameter BYPASS, default 1, enables same-cycle write-to-read forwarding.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 ra  in  NRP x 5  read addresses.
REQ-008 rd  out  NRP x XLEN  read data.
REQ-009 rstall  out  NRP  read port operand not ready.
REQ-010 wa, wd, we  in  NWP x 5, NWP x XLEN, NWP  write address, data, enable.
REQ-011 iss_rd, iss_v  in  5, 1  issue of an instruction that will write iss_rd (marks register busy).
REQ-012 flush  in  1  clears all busy bits (pipeline kill).
REQ-013 err  out  1  sticky flag: out-of-range address used in E mode.

Function
REQ-014 x0 reads return 0, never stall; writes and issues to x0 are ignored.
REQ-015 Register write occurs on the clock edge where we[i]=1; data visible to the read array from the next cycle.
REQ-016 With BYPASS=1, a read whose ra matches an active same-cycle wa returns that wd combinationally; with BYPASS=0 it returns the stored value.
REQ-017 Multiple write ports to the same address in one cycle: highest port index wins, for both storage and bypass.
REQ-018 Scoreboard: busy[r] set on edge with iss_v=1 and iss_rd=r; cleared on edge with any we[i]=1 and wa[i]=r.
REQ-019 Simultaneous issue and write to same r: busy remains set (new producer outstanding).
REQ-020 flush on an edge clears every busy bit; an issue in the same cycle is discarded; writes in the same cycle still update storage.
REQ-021 rstall[p] = busy[ra[p]] and not (BYPASS and a same-cycle write to ra[p]); purely combinational.
REQ-022 E mode: address >= 16 on any read, write or issue reads as 0, writes/issues ignored, err set on next edge and held until reset.
REQ-023 Read paths combinational, zero latency; scoreboard and storage single-cycle update.

Reset
REQ-024 On rst_n low: all registers 0, all busy bits 0, err 0, asynchronously.
REQ-025 Reset asserted mid-operation discards pending writes/issues of that cycle; outputs reflect reset state while rst_n low.
REQ-026 First active edge after rst_n deasserts performs normal update.

Structure
REQ-027 config_t, XLEN, E_SUPPORTED and a regaddr_t (5-bit) typedef live in config_pkg; NUMREGS derived locally.
REQ-028 Scoreboard implemented as sub-module core_scoreboard (busy vector, issue/clear/flush, stall query).
REQ-029 Storage, write-priority merge and bypass muxes remain in core_regfile_sb.

Verification
REQ-030 Write x5=0xDEADBEEF on port0, read ra=5 same cycle -> BYPASS=1: 0xDEADBEEF; BYPASS=0: 0 then 0xDEADBEEF next cycle.
REQ-031 Ports 0 and 1 both write x7 (0x11, 0x22) -> x7 reads 0x22 thereafter.
REQ-032 Issue x3, read x3 -> rstall=1; next cycle write x3=0x55 -> rstall=0 that cycle (BYPASS=1), rd=0x55.
REQ-033 Issue x4 and write x4 same cycle -> busy[4] stays 1; flush -> rstall on x4 drops next cycle.
REQ-034 E_SUPPORTED=1, write x20=0x1 -> err=1 next cycle, read x20=0, x0 write ignored, reads 0.
REQ-035 Assert rst_n low mid-burst of writes -> all reads 0, rstall 0, err 0 immediately.
